// File: rtl/pop_ack_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pop_ack_responder_pkg
// Description : Shared types and defaults for the pop_ack responder:
//               read-side FSM state type, default depth and data width,
//               and a saturating increment used by the optional statistics.
// Revision    : 1.0 - initial release
// ============================================================================
package pop_ack_responder_pkg;

  localparam int POP_ACK_DEPTH_DEF  = 4;
  localparam int POP_ACK_DATA_W_DEF = 32;

  typedef logic [POP_ACK_DATA_W_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } pop_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pop_ack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pop_ack_fifo
// Description : Circular word buffer with write/read pointers and occupancy
//               count. The head word is presented combinationally from
//               storage; full/empty are decoded from the registered count.
// Ports       : clk, rst (async, active-high)
//               wr_en_i / wr_data_i : push one word (caller guarantees !full)
//               rd_en_i             : drop head word (caller guarantees !empty)
//               head_o              : oldest buffered word
//               count_o, full_o, empty_o : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module pop_ack_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  // Storage is not reset: contents are only observable through the count.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pop_ack_responder.sv
`default_nettype none
// ============================================================================
// Module      : pop_ack_responder
// Description : Responder end of the pop_ack protocol. Buffers a rdy/vld
//               write stream and answers each single-cycle pop request with
//               exactly one single-cycle ack carrying the oldest word.
// Ports       : clk, rst (async, active-high)
//               aIn_valid_i, aIn_data_i, aIn_ready_o : rdy/vld write side
//               dIn_pop_i, dIn_ack_o, dIn_data_o     : pop/ack read side
//               err_pop_o   : sticky, pop seen while one was outstanding
//               stat_pops_o, stat_wait_o : only with POP_ACK_RESPONDER_STATS_EN
// Config      : `define POP_ACK_RESPONDER_STATS_EN adds saturating counters
//               of acks issued and cycles spent waiting for data.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_ack_responder
  import pop_ack_responder_pkg::*;
#(
  parameter int DATA_W = POP_ACK_DATA_W_DEF,
  parameter int DEPTH  = POP_ACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aIn_valid_i,
  input  logic [DATA_W-1:0] aIn_data_i,
  output logic              aIn_ready_o,
  input  logic              dIn_pop_i,
  output logic              dIn_ack_o,
  output logic [DATA_W-1:0] dIn_data_o,
  output logic              err_pop_o
`ifdef POP_ACK_RESPONDER_STATS_EN
  ,
  output logic [31:0]       stat_pops_o,
  output logic [31:0]       stat_wait_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  pop_state_t        state_q, state_d;
  logic              rst_done_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q;

  logic              wr_en;
  logic              rd_en;
  logic              ack;
  logic [DATA_W-1:0] head;
  logic [AW:0]       count;
  logic              full;
  logic              empty;

  // Ready depends only on registered state, never on the pop input.
  // rst_done_q keeps ready low while reset is held.
  assign aIn_ready_o = rst_done_q & ~full;
  assign wr_en       = aIn_valid_i & aIn_ready_o;

  pop_ack_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (aIn_data_i),
    .rd_en_i   (rd_en),
    .head_o    (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dIn_pop_i) state_d = empty ? WAIT : ACK;
      end
      WAIT: begin
        if (!empty) state_d = ACK;
      end
      ACK: begin
        // A pop arriving during the ack is a fresh request. The head is
        // consumed this cycle, so another word must remain (count >= 2)
        // or be written right now for a back-to-back ack.
        if (dIn_pop_i) begin
          state_d = (|count[AW:1] || wr_en) ? ACK : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack   = (state_q == ACK);
    rd_en = ack;
  end

  assign dIn_ack_o  = ack;
  // Head is shown during the ack; otherwise the last acked word is held.
  assign dIn_data_o = ack ? head : data_q;
  assign err_pop_o  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done_q <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (state_q == WAIT && dIn_pop_i) err_q <= 1'b1;
      if (ack) data_q <= head;
    end
  end

`ifdef POP_ACK_RESPONDER_STATS_EN
  logic [31:0] stat_pops_q;
  logic [31:0] stat_wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pops_q <= '0;
      stat_wait_q <= '0;
    end else begin
      if (ack)              stat_pops_q <= sat_inc(stat_pops_q);
      if (state_q == WAIT)  stat_wait_q <= sat_inc(stat_wait_q);
    end
  end

  assign stat_pops_o = stat_pops_q;
  assign stat_wait_o = stat_wait_q;
`endif

endmodule
`default_nettype wire
